// File: rtl/fir_err_stats.sv
// ---------------------------------------------------------------------------
// fir_err_stats
//
// Compares the output of an approximate FIR filter against an exact reference
// over a run of test_size sample pairs. For every accepted pair the error
// (approx - exact) is computed at WIDTH+1 bits. The block accumulates the
// signed error sum, the saturating squared-error sum, the min/max error and
// the number of mismatching pairs.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, test_size    begin a run (honoured in IDLE only), run length
//   in_valid, in_ready  handshake for the exact/approx pair
//   exact, approx       signed WIDTH-bit filter outputs
//   busy, done          run in progress / one-cycle completion pulse
//   count               pairs accumulated in the current or last run
//   err_sum             signed sum of errors (wraps modulo 2^ACC_W)
//   err_sq_sum          unsigned sum of squared errors (saturates)
//   err_min, err_max    extreme signed errors of the run
//   mismatch_cnt        pairs with approx != exact
//
// Timing: acceptance -> stage 1 (error register) -> stage 2 (statistics),
// so statistics reflect a pair two edges after it is accepted.
// ---------------------------------------------------------------------------
module fir_err_stats #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32,
   parameter int ACC_W = 80
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CNT_W-1:0]        test_size,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] exact,
   input  logic signed [WIDTH-1:0] approx,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_W-1:0]        count,
   output logic signed [ACC_W-1:0] err_sum,
   output logic [ACC_W-1:0]        err_sq_sum,
   output logic signed [WIDTH:0]   err_min,
   output logic signed [WIDTH:0]   err_max,
   output logic [CNT_W-1:0]        mismatch_cnt
);

   localparam int EW    = WIDTH + 1;
   localparam int SQ_W  = 2 * EW;
   // One spare bit above the wider operand so the carry out is visible.
   localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state_reg, state_next;

   logic [CNT_W-1:0] size_reg;
   logic [CNT_W-1:0] acc_cnt_reg, acc_cnt_next;
   logic             drain_cnt_reg, drain_cnt_next;
   logic             accept;
   logic             start_run;

   // Stage 1: registered error
   logic                  s1_valid_reg;
   logic signed [EW-1:0]  s1_err_reg;

   // Stage 2: statistics
   logic [CNT_W-1:0]        count_reg;
   logic signed [ACC_W-1:0] err_sum_reg;
   logic [ACC_W-1:0]        err_sq_sum_reg;
   logic signed [EW-1:0]    err_min_reg;
   logic signed [EW-1:0]    err_max_reg;
   logic [CNT_W-1:0]        mismatch_cnt_reg;

   // Stage 2 combinational helpers
   logic [EW-1:0]           err_abs;
   logic [SQ_W-1:0]         err_sq;
   logic [SUM_W-1:0]        sq_sum_wide;
   logic [ACC_W-1:0]        sq_sum_next;
   logic signed [ACC_W-1:0] err_ext;

   // ------------------------------------------------------------------
   // FSM: next state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      acc_cnt_next   = acc_cnt_reg;
      drain_cnt_next = drain_cnt_reg;
      in_ready       = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      accept         = 1'b0;
      start_run      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next   = RUN;
               acc_cnt_next = '0;
               start_run    = 1'b1;
            end
         end

         RUN: begin
            busy         = 1'b1;
            in_ready     = (acc_cnt_reg < size_reg);
            accept       = in_valid && in_ready;
            acc_cnt_next = acc_cnt_reg + CNT_W'(accept);
            // Leave on the edge where the accepted count reaches the size;
            // a zero-length run leaves on its first RUN edge.
            if (acc_cnt_next == size_reg) begin
               state_next     = DRAIN;
               drain_cnt_next = 1'b0;
            end
         end

         DRAIN: begin
            busy = 1'b1;
            // Two cycles: the last pair leaves stage 1 on the first, its
            // statistics are final by the second.
            if (drain_cnt_reg && !s1_valid_reg) begin
               state_next = DONE;
            end else begin
               drain_cnt_next = 1'b1;
            end
         end

         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Stage 2 arithmetic
   // ------------------------------------------------------------------
   // Magnitude is taken unsigned so that -2^WIDTH squares correctly.
   always_comb begin
      err_abs     = s1_err_reg[EW-1] ? (~s1_err_reg + EW'(1)) : s1_err_reg;
      err_sq      = SQ_W'(err_abs) * SQ_W'(err_abs);
      sq_sum_wide = SUM_W'(err_sq_sum_reg) + SUM_W'(err_sq);
      if (|sq_sum_wide[SUM_W-1:ACC_W]) begin
         sq_sum_next = '1;
      end else begin
         sq_sum_next = sq_sum_wide[ACC_W-1:0];
      end
   end

   generate
      if (ACC_W > EW) begin : g_err_ext
         assign err_ext = {{(ACC_W-EW){s1_err_reg[EW-1]}}, s1_err_reg};
      end else begin : g_err_trunc
         assign err_ext = s1_err_reg[ACC_W-1:0];
      end
   endgenerate

   // ------------------------------------------------------------------
   // State, pipeline and statistics registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         size_reg         <= '0;
         acc_cnt_reg      <= '0;
         drain_cnt_reg    <= 1'b0;
         s1_valid_reg     <= 1'b0;
         s1_err_reg       <= '0;
         count_reg        <= '0;
         err_sum_reg      <= '0;
         err_sq_sum_reg   <= '0;
         err_min_reg      <= '0;
         err_max_reg      <= '0;
         mismatch_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         acc_cnt_reg   <= acc_cnt_next;
         drain_cnt_reg <= drain_cnt_next;

         // Stage 1: error at WIDTH+1 bits cannot overflow.
         s1_valid_reg <= accept;
         if (accept) begin
            s1_err_reg <= {approx[WIDTH-1], approx} - {exact[WIDTH-1], exact};
         end

         // Stage 2. A start is only taken in IDLE, where the pipeline is
         // always empty, so the two branches never compete for a sample.
         if (start_run) begin
            size_reg         <= test_size;
            count_reg        <= '0;
            err_sum_reg      <= '0;
            err_sq_sum_reg   <= '0;
            err_min_reg      <= '0;
            err_max_reg      <= '0;
            mismatch_cnt_reg <= '0;
         end else if (s1_valid_reg) begin
            count_reg      <= count_reg + CNT_W'(1);
            err_sum_reg    <= err_sum_reg + err_ext;
            err_sq_sum_reg <= sq_sum_next;
            if (s1_err_reg != '0) begin
               mismatch_cnt_reg <= mismatch_cnt_reg + CNT_W'(1);
            end
            // count is still zero for the first sample of a run: it seeds
            // both extremes instead of comparing against the cleared zero.
            if (count_reg == '0) begin
               err_min_reg <= s1_err_reg;
               err_max_reg <= s1_err_reg;
            end else begin
               if (s1_err_reg < err_min_reg) begin
                  err_min_reg <= s1_err_reg;
               end
               if (s1_err_reg > err_max_reg) begin
                  err_max_reg <= s1_err_reg;
               end
            end
         end
      end
   end

   assign count        = count_reg;
   assign err_sum      = err_sum_reg;
   assign err_sq_sum   = err_sq_sum_reg;
   assign err_min      = err_min_reg;
   assign err_max      = err_max_reg;
   assign mismatch_cnt = mismatch_cnt_reg;

endmodule

// File: tb/tb_fir_err_stats.sv
// ---------------------------------------------------------------------------
// tb_fir_err_stats
//
// Self-checking bench for fir_err_stats: a table of directed runs with
// hand-computed results, hand-written reset/priority sequences, and random
// runs checked against an arithmetic reference model over the sample queues.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fir_err_stats;

   localparam int WIDTH = 32;
   localparam int CNT_W = 32;
   localparam int ACC_W = 80;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic [CNT_W-1:0]        test_size;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] exact;
   logic signed [WIDTH-1:0] approx;
   logic                    busy;
   logic                    done;
   logic [CNT_W-1:0]        count;
   logic signed [ACC_W-1:0] err_sum;
   logic [ACC_W-1:0]        err_sq_sum;
   logic signed [WIDTH:0]   err_min;
   logic signed [WIDTH:0]   err_max;
   logic [CNT_W-1:0]        mismatch_cnt;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fir_err_stats #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .start(start), .test_size(test_size),
      .in_valid(in_valid), .in_ready(in_ready), .exact(exact), .approx(approx),
      .busy(busy), .done(done), .count(count), .err_sum(err_sum),
      .err_sq_sum(err_sq_sum), .err_min(err_min), .err_max(err_max),
      .mismatch_cnt(mismatch_cnt)
   );

   // Sample pairs of the current run and reference results
   longint       q_ex[$];
   longint       q_ap[$];
   longint       m_cnt, m_sum, m_min, m_max, m_mis;
   logic [127:0] m_sq;

   typedef struct {
      int           size;
      longint       ex[4];
      longint       ap[4];
      int           gap_at;
      int           gap_len;
      int           restart_at;
      longint       e_cnt;
      longint       e_sum;
      logic [127:0] e_sq;
      longint       e_min;
      longint       e_max;
      longint       e_mis;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic signed [127:0] act,
                        input logic signed [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference: statistics over the whole run from plain arithmetic.
   function automatic void model();
      logic [127:0] limit;
      limit = (128'd1 << ACC_W) - 128'd1;
      m_cnt = q_ex.size();
      m_sum = 0; m_sq = 0; m_min = 0; m_max = 0; m_mis = 0;
      for (int i = 0; i < q_ex.size(); i++) begin
         longint       e;
         longint       a;
         logic [127:0] s;
         e = q_ap[i] - q_ex[i];
         a = (e < 0) ? -e : e;
         s = 128'(a) * 128'(a);
         m_sum += e;
         m_sq = (m_sq + s > limit) ? limit : m_sq + s;
         if (i == 0 || e < m_min) m_min = e;
         if (i == 0 || e > m_max) m_max = e;
         if (e != 0) m_mis++;
      end
   endfunction

   function automatic longint partial_sum(input int n);
      longint s = 0;
      for (int i = 0; i < n; i++) s += q_ap[i] - q_ex[i];
      return s;
   endfunction

   // One complete run using q_ex/q_ap; checks latency, handshake, done
   // timing, final results and result hold after completion.
   task automatic do_run(input string tag, input int size, input int gap_at,
                         input int gap_len, input int restart_at, input bit rand_valid,
                         input longint e_cnt, input longint e_sum, input logic [127:0] e_sq,
                         input longint e_min, input longint e_max, input longint e_mis);
      int         idx = 0;
      int         idx_prev = 0;
      int         gap_used = 0;
      int         drain_edge;
      bit         got_done = 0;
      logic [63:0] t;
      drain_edge = (size == 0) ? 1 : -1;
      @(negedge clk);
      start = 1'b1; test_size = size; in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy_after_start"}, busy, 1);
      for (int cyc = 0; cyc < 400; cyc++) begin
         start = 1'b0;
         if (done) begin
            got_done = 1;
            check({tag, " done_cycle"}, cyc, drain_edge + 2);
            break;
         end
         check({tag, " count_latency"}, count, idx_prev);
         check({tag, " err_sum_partial"}, err_sum, partial_sum(idx_prev));
         check({tag, " in_ready"}, in_ready, (idx < size));
         idx_prev = idx;
         if (cyc == restart_at) begin
            start = 1'b1; test_size = size + 5;
         end
         exact = $urandom; approx = $urandom;
         if (idx < size) begin
            bit v = 1;
            if (idx == gap_at && gap_used < gap_len) begin
               v = 0; gap_used++;
            end
            if (rand_valid && $urandom_range(3) == 0) v = 0;
            in_valid = v;
            if (v) begin
               t = q_ex[idx]; exact = t[WIDTH-1:0];
               t = q_ap[idx]; approx = t[WIDTH-1:0];
               idx++;
               if (idx == size) drain_edge = cyc + 1;
            end
         end else begin
            in_valid = 1'b1;   // noise while not ready
         end
         @(negedge clk);
      end
      check({tag, " done_seen"}, got_done, 1);
      check({tag, " count"}, count, e_cnt);
      check({tag, " err_sum"}, err_sum, e_sum);
      check({tag, " err_sq_sum"}, err_sq_sum, e_sq);
      check({tag, " err_min"}, err_min, e_min);
      check({tag, " err_max"}, err_max, e_max);
      check({tag, " mismatch_cnt"}, mismatch_cnt, e_mis);
      in_valid = 1'b1; exact = $urandom; approx = $urandom;
      @(negedge clk);
      check({tag, " done_one_cycle"}, done, 0);
      check({tag, " idle_not_busy"}, busy, 0);
      repeat (2) @(negedge clk);
      check({tag, " hold_count"}, count, e_cnt);
      check({tag, " hold_err_sum"}, err_sum, e_sum);
      in_valid = 1'b0;
      $display("run %s size=%0d count=%0d err_sum=%0d err_sq_sum=%0d min=%0d max=%0d mis=%0d",
               tag, size, count, err_sum, err_sq_sum, err_min, err_max, mismatch_cnt);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " in_ready"}, in_ready, 0);
      check({tag, " done"}, done, 0);
      check({tag, " count"}, count, 0);
      check({tag, " err_sum"}, err_sum, 0);
      check({tag, " err_sq_sum"}, err_sq_sum, 0);
      check({tag, " err_min"}, err_min, 0);
      check({tag, " err_max"}, err_max, 0);
      check({tag, " mismatch_cnt"}, mismatch_cnt, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; test_size = '0;
      exact = '0; approx = '0;

      tbl[0] = '{4, '{10, -5, 7, 0}, '{12, -9, 7, 3}, -1, 0, -1, 4, 1, 128'd29, -4, 3, 3};
      tbl[1] = '{0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, -1, 0, -1, 0, 0, 128'd0, 0, 0, 0};
      tbl[2] = '{1, '{-64'sd2147483648, 0, 0, 0}, '{64'sd2147483647, 0, 0, 0}, -1, 0, -1,
                 1, 64'sd4294967295, 128'hFFFF_FFFE_0000_0001, 64'sd4294967295,
                 64'sd4294967295, 1};
      tbl[3] = '{2, '{-1, 5, 0, 0}, '{-1, -5, 0, 0}, -1, 0, -1, 2, -10, 128'd100, -10, 0, 1};
      tbl[4] = '{3, '{100, 3, 0, 0}, '{50, 1, -7, 0}, -1, 0, -1, 3, -59, 128'd2553, -50, -2, 3};
      tbl[5] = '{3, '{1, 2, 9, 0}, '{4, -2, 9, 0}, 1, 5, -1, 3, -1, 128'd25, -4, 3, 2};
      tbl[6] = '{3, '{1, 2, 9, 0}, '{4, -2, 9, 0}, -1, 0, -1, 3, -1, 128'd25, -4, 3, 2};
      tbl[7] = '{4, '{10, -5, 7, 0}, '{12, -9, 7, 3}, -1, 0, 2, 4, 1, 128'd29, -4, 3, 3};

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Directed table
      for (int v = 0; v < 8; v++) begin
         q_ex.delete(); q_ap.delete();
         for (int i = 0; i < tbl[v].size; i++) begin
            q_ex.push_back(tbl[v].ex[i]);
            q_ap.push_back(tbl[v].ap[i]);
         end
         do_run($sformatf("vec%0d", v), tbl[v].size, tbl[v].gap_at, tbl[v].gap_len,
                tbl[v].restart_at, 1'b0, tbl[v].e_cnt, tbl[v].e_sum, tbl[v].e_sq,
                tbl[v].e_min, tbl[v].e_max, tbl[v].e_mis);
      end

      // Reset during the second sample of a four-sample run
      @(negedge clk);
      start = 1'b1; test_size = 4;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; exact = 10; approx = 12;
      @(negedge clk);
      exact = -5; approx = -9; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      check_all_zero("midrun_rst");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("midrun_rst no_done%0d", i), done, 0);
      end
      check("midrun_rst count_stays0", count, 0);
      check("midrun_rst sum_stays0", err_sum, 0);
      q_ex.delete(); q_ap.delete();
      q_ex.push_back(-3); q_ap.push_back(8);
      model();
      do_run("after_rst", 1, -1, 0, -1, 1'b0, m_cnt, m_sum, m_sq, m_min, m_max, m_mis);

      // Reset has priority over a simultaneous start
      @(negedge clk);
      rst = 1'b1; start = 1'b1; test_size = 2;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check_all_zero("rst_vs_start");
      @(negedge clk);
      check("rst_vs_start still_idle", busy, 0);

      // Random runs against the reference model
      for (int r = 0; r < 16; r++) begin
         int size;
         size = $urandom_range(1, 10);
         q_ex.delete(); q_ap.delete();
         for (int i = 0; i < size; i++) begin
            if (r % 2 == 0) begin
               q_ex.push_back(longint'($signed($urandom)));
               q_ap.push_back(longint'($signed($urandom)));
            end else begin
               q_ex.push_back(longint'($urandom_range(0, 200)) - 100);
               q_ap.push_back(longint'($urandom_range(0, 200)) - 100);
            end
         end
         model();
         do_run($sformatf("rand%0d", r), size, -1, 0, (r % 4 == 3) ? 1 : -1, 1'b1,
                m_cnt, m_sum, m_sq, m_min, m_max, m_mis);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fir_err_stats.md
FIR_ERR_STATS -- requirements
Module: fir_err_stats

Interface
REQ-001 Parameter WIDTH, default 32: width of the signed filter output samples compared.
REQ-002 Parameter CNT_W, default 32: width of the test-size and sample counters.
REQ-003 Parameter ACC_W, default 80: width of the error-sum and squared-error-sum accumulators.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-007 test_size  input  CNT_W  number of sample pairs in the run; captured on an accepted start.
REQ-008 in_valid  input  1  exact/approx pair presented.
REQ-009 in_ready  output  1  block accepts a pair this cycle.
REQ-010 exact  input  WIDTH signed  output of the accurate filter.
REQ-011 approx  input  WIDTH signed  output of the approximate filter under test.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  one-cycle pulse when the run's results are final.
REQ-014 count  output  CNT_W  pairs accumulated in the current or last run.
REQ-015 err_sum  output  ACC_W signed  sum of (approx - exact).
REQ-016 err_sq_sum  output  ACC_W unsigned  sum of (approx - exact)^2, saturating.
REQ-017 err_min / err_max  output  WIDTH+1 signed each  smallest and largest error in the run.
REQ-018 mismatch_cnt  output  CNT_W  pairs with approx != exact.

Function
REQ-019 The block SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE->RUN SHALL occur on start; test_size SHALL be latched; every statistic SHALL clear to 0 in the same edge.
REQ-021 A start seen outside IDLE SHALL be ignored.
REQ-022 in_ready SHALL be 1 only in RUN while accepted < latched test_size.
REQ-023 A pair SHALL be accepted exactly when in_valid and in_ready are both 1.
REQ-024 Pipeline stage 1: on acceptance, err = approx - exact SHALL be registered at WIDTH+1 bits, with no overflow.
REQ-025 Pipeline stage 2, one cycle later, SHALL update count, err_sum (sign-extended add), err_sq_sum, err_min, err_max and mismatch_cnt.
REQ-026 Statistics latency SHALL be 2 cycles from acceptance.
REQ-027 The first sample of a run SHALL load both err_min and err_max; later samples SHALL compare signed.
REQ-028 err_sq_sum SHALL saturate at all-ones and SHALL never wrap.
REQ-029 err_sum SHALL wrap modulo 2^ACC_W; the default widths cannot overflow at CNT_W=32.
REQ-030 RUN->DRAIN SHALL occur on the edge where accepted reaches test_size.
REQ-031 DRAIN SHALL last until stage 1 and stage 2 hold no pending sample (2 cycles).
REQ-032 DRAIN->DONE SHALL follow; done SHALL be 1 for the single DONE cycle, then the state SHALL return to IDLE.
REQ-033 test_size = 0 SHALL go IDLE->RUN->DRAIN->DONE with no pair accepted; all statistics SHALL be 0.
REQ-034 In IDLE, after DONE, results SHALL hold their values until the next accepted start.
REQ-035 in_valid low mid-run SHALL stall with no statistics change; there SHALL be no timeout.
REQ-036 Inputs SHALL be ignored whenever in_ready is 0.

Reset
REQ-037 While rst is 1 at an edge, the state SHALL become IDLE.
REQ-038 In the same case, pipeline valids SHALL clear.
REQ-039 In the same case, in_ready, busy and done SHALL be 0.
REQ-040 In the same case, count, err_sum, err_sq_sum, err_min, err_max and mismatch_cnt SHALL be 0.
REQ-041 Reset mid-run SHALL abandon the run; no done pulse SHALL follow.
REQ-042 rst SHALL take priority over start in the same cycle.

Verification
REQ-043 Pulse start with test_size=4, then feed pairs (exact,approx) = (10,12), (-5,-9), (7,7), (0,3), valid every cycle -> done once, 2 cycles after the 4th acceptance plus the DONE transition; count=4, err_sum=1, err_sq_sum=29, err_min=-4, err_max=3, mismatch_cnt=3.
REQ-044 test_size=0 -> in_ready never 1; done 3 cycles after start; all statistics 0.
REQ-045 exact=-2^31, approx=2^31-1, test_size=1 -> err_max = err_min = 2^32-1; err_sq_sum=(2^32-1)^2; err_sum=2^32-1.
REQ-046 Hold in_valid low for 5 cycles in the middle of a 3-sample run -> statistics unchanged during the gap; final values identical to a gapless run.
REQ-047 Assert rst during the 2nd sample of a 4-sample run -> next cycle IDLE with all outputs 0, and no done; a new start with test_size=1 then completes normally.
REQ-048 Pulse start while busy with a different test_size -> ignored; the run completes using the originally latched size.
